pcs_block_lock_ctrl: RTL and testbench

- Controls the 64b/66b receive path: runs the sync-header block-lock state machine, requests gearbox bit-slips and sequences the 64-bit self-synchronising descrambler.
- Sits between the RX gearbox, which supplies the 2-bit header plus a 64-bit payload per block, and the descrambler.
- Drives the descrambler's enable and pop, and qualifies descrambled output with block_lock.

---
 rtl/pcs_block_lock_ctrl.sv | 152 +++++++++++++++
 tb/tb_pcs_block_lock_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pcs_block_lock_ctrl.sv
// 64b/66b receive block-lock controller: sync-header lock FSM, gearbox slip requests
// and descrambler enable/pop sequencing.
module pcs_block_lock_ctrl #(
    parameter int unsigned GOOD_TO_LOCK  = 64,
    parameter int unsigned WINDOW        = 64,
    parameter int unsigned BAD_TO_UNLOCK = 16,
    parameter int unsigned SLIP_WAIT     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_enable,
    input  logic       hdr_valid,
    input  logic [1:0] hdr,
    output logic       slip,
    output logic       block_lock,
    output logic       desc_enable,
    output logic       desc_pop,
    output logic       out_valid,
    output logic       err_blk,
    output logic [7:0] slip_cnt
);

    localparam int unsigned MaxAb    = (GOOD_TO_LOCK > WINDOW) ? GOOD_TO_LOCK : WINDOW;
    localparam int unsigned MaxCd    = (BAD_TO_UNLOCK > SLIP_WAIT) ? BAD_TO_UNLOCK : SLIP_WAIT;
    localparam int unsigned MaxParam = (MaxAb > MaxCd) ? MaxAb : MaxCd;
    localparam int unsigned CW       = $clog2(MaxParam) + 1;

    localparam logic [CW-1:0] GoodLast = CW'(GOOD_TO_LOCK - 1);
    localparam logic [CW-1:0] WinLast  = CW'(WINDOW - 1);
    localparam logic [CW-1:0] BadLast  = CW'(BAD_TO_UNLOCK - 1);
    localparam logic [CW-1:0] WaitLast = CW'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {StHunt, StSlip, StLocked} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] good_q, good_d;
    logic [CW-1:0] win_q, win_d;
    logic [CW-1:0] bad_q, bad_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          slip_q, slip_d;
    logic          lock_q, lock_d;
    logic          err_q, err_d;
    logic          desc_en_q;
    logic [7:0]    scnt_q, scnt_d;

    logic blk;
    logic hdr_ok;

    assign blk    = hdr_valid & in_enable;
    assign hdr_ok = hdr[1] ^ hdr[0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StHunt;
            good_q    <= '0;
            win_q     <= '0;
            bad_q     <= '0;
            wait_q    <= '0;
            slip_q    <= 1'b0;
            lock_q    <= 1'b0;
            err_q     <= 1'b0;
            desc_en_q <= 1'b0;
            scnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            good_q    <= good_d;
            win_q     <= win_d;
            bad_q     <= bad_d;
            wait_q    <= wait_d;
            slip_q    <= slip_d;
            lock_q    <= lock_d;
            err_q     <= err_d;
            desc_en_q <= in_enable;
            scnt_q    <= scnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        win_d   = win_q;
        bad_d   = bad_q;
        wait_d  = wait_q;
        slip_d  = 1'b0;
        lock_d  = lock_q;
        err_d   = 1'b0;
        scnt_d  = scnt_q;
        if (blk) begin
            unique case (state_q)
                StHunt: begin
                    if (hdr_ok) begin
                        if (good_q == GoodLast) begin
                            state_d = StLocked;
                            lock_d  = 1'b1;
                            good_d  = '0;
                            win_d   = '0;
                            bad_d   = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        state_d = StSlip;
                        good_d  = '0;
                        wait_d  = '0;
                        slip_d  = 1'b1;
                        scnt_d  = (scnt_q != 8'hff) ? scnt_q + 8'd1 : scnt_q;
                    end
                end
                StSlip: begin
                    // Headers here straddle the old alignment, so only their count matters.
                    if (wait_q == WaitLast) begin
                        state_d = StHunt;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                StLocked: begin
                    err_d = !hdr_ok;
                    // Unlock takes priority over the window rollover on the same block.
                    if (!hdr_ok && bad_q == BadLast) begin
                        state_d = StSlip;
                        lock_d  = 1'b0;
                        win_d   = '0;
                        bad_d   = '0;
                        wait_d  = '0;
                        slip_d  = 1'b1;
                        scnt_d  = (scnt_q != 8'hff) ? scnt_q + 8'd1 : scnt_q;
                    end else if (win_q == WinLast) begin
                        win_d = '0;
                        bad_d = '0;
                    end else begin
                        win_d = win_q + 1'b1;
                        bad_d = bad_q + CW'(!hdr_ok);
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_comb begin
        desc_pop    = blk & (state_q != StSlip);
        out_valid   = blk & lock_q;
        slip        = slip_q;
        block_lock  = lock_q;
        err_blk     = err_q;
        desc_enable = desc_en_q;
        slip_cnt    = scnt_q;
    end

endmodule

// File: tb/tb_pcs_block_lock_ctrl.sv
// Scoreboard bench for pcs_block_lock_ctrl: directed scenarios followed by randomized traffic.
module tb_pcs_block_lock_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_enable = 1'b0;
    logic       hdr_valid = 1'b0;
    logic [1:0] hdr = 2'b00;
    logic       slip, block_lock, desc_enable, desc_pop, out_valid, err_blk;
    logic [7:0] slip_cnt;

    pcs_block_lock_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_enable  (in_enable),
        .hdr_valid  (hdr_valid),
        .hdr        (hdr),
        .slip       (slip),
        .block_lock (block_lock),
        .desc_enable(desc_enable),
        .desc_pop   (desc_pop),
        .out_valid  (out_valid),
        .err_blk    (err_blk),
        .slip_cnt   (slip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pop;
        logic       ov;
        logic       lock;
        logic       slp;
        logic       err;
        logic       den;
        logic [7:0] scnt;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   armed = 0;

    // Reference model: lock status plus plain counts of what has happened since each milestone.
    bit m_locked = 0, m_slipping = 0, m_slip_out = 0, m_err_out = 0, m_den = 0;
    int m_run = 0, m_wait_left = 0, m_win_blocks = 0, m_win_bads = 0, m_slips = 0;

    function automatic void start_slip();
        m_slipping  = 1;
        m_wait_left = 4;
        m_slip_out  = 1;
        m_slips     = (m_slips < 255) ? m_slips + 1 : 255;
    endfunction

    function automatic void model_step(bit rst, bit en, bit hv, logic [1:0] h);
        bit good;
        good = (h == 2'b01) || (h == 2'b10);
        if (!rst) begin
            m_locked = 0; m_slipping = 0; m_slip_out = 0; m_err_out = 0; m_den = 0;
            m_run = 0; m_wait_left = 0; m_win_blocks = 0; m_win_bads = 0; m_slips = 0;
            return;
        end
        m_slip_out = 0;
        m_err_out  = 0;
        m_den      = en;
        if (!(en && hv)) return;
        if (m_slipping) begin
            m_wait_left--;
            if (m_wait_left == 0) m_slipping = 0;
        end else if (!m_locked) begin
            if (good) begin
                m_run++;
                if (m_run == 64) begin
                    m_locked = 1; m_run = 0; m_win_blocks = 0; m_win_bads = 0;
                end
            end else begin
                m_run = 0;
                start_slip();
            end
        end else begin
            m_win_blocks++;
            if (!good) begin
                m_win_bads++;
                m_err_out = 1;
            end
            if (!good && m_win_bads == 16) begin
                m_locked = 0; m_win_blocks = 0; m_win_bads = 0;
                start_slip();
            end else if (m_win_blocks == 64) begin
                m_win_blocks = 0; m_win_bads = 0;
            end
        end
    endfunction

    task automatic cycle(input bit rst, input bit en, input bit hv, input logic [1:0] h);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n = rst; in_enable = en; hdr_valid = hv; hdr = h;
        e.pop  = hv && en && !m_slipping;
        e.ov   = hv && en && m_locked;
        e.lock = m_locked;
        e.slp  = m_slip_out;
        e.err  = m_err_out;
        e.den  = m_den;
        e.scnt = 8'(m_slips);
        if (armed) exp_q.push_back(e);
        armed = 1;
        model_step(rst, en, hv, h);
    endtask

    task automatic blocks(input int n, input logic [1:0] h);
        for (int i = 0; i < n; i++) cycle(1, 1, 1, h);
    endtask

    always @(negedge clk) begin
        exp_t e, g;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {desc_pop, out_valid, block_lock, slip, err_blk, desc_enable, slip_cnt};
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL outputs cyc=%0d got pop=%b ov=%b lock=%b slip=%b err=%b den=%b scnt=%0d required pop=%b ov=%b lock=%b slip=%b err=%b den=%b scnt=%0d",
                         cyc, g.pop, g.ov, g.lock, g.slp, g.err, g.den, g.scnt,
                         e.pop, e.ov, e.lock, e.slp, e.err, e.den, e.scnt);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 2'b00);
        // Lock on 64 valid headers.
        blocks(64, 2'b01);
        // Window with 15 bad headers: lock holds.
        for (int i = 0; i < 64; i++) cycle(1, 1, 1, (i % 4 == 1 && i < 60) ? 2'b11 : 2'b10);
        // 16th bad header lands on the window's last block: unlock wins.
        for (int i = 0; i < 64; i++)
            cycle(1, 1, 1, ((i % 4 == 3 && i < 60) || i == 63) ? 2'b00 : 2'b01);
        blocks(4, 2'b01);
        // Hunt: 10 valid then invalid, wait out the slip, relock.
        blocks(10, 2'b01);
        cycle(1, 1, 1, 2'b11);
        blocks(4, 2'b01);
        blocks(63, 2'b10);
        cycle(1, 1, 0, 2'b01);
        blocks(3, 2'b01);
        // Disable mid-hunt, then reset while in SLIP.
        cycle(0, 1, 0, 2'b00);
        blocks(20, 2'b01);
        for (int i = 0; i < 5; i++) cycle(1, 0, 1, 2'b11);
        blocks(20, 2'b01);
        cycle(1, 1, 1, 2'b00);
        cycle(1, 0, 1, 2'b01);
        blocks(1, 2'b01);
        cycle(0, 1, 1, 2'b01);
        blocks(66, 2'b01);
        // Saturate the slip counter.
        cycle(0, 1, 0, 2'b00);
        for (int s = 0; s < 300; s++) begin
            cycle(1, 1, 1, 2'b11);
            blocks(4, 2'b10);
        end
        // Randomized traffic with varying error density.
        for (int i = 0; i < 3000; i++) begin
            int unsigned rate;
            logic [1:0] h;
            rate = (i < 1500) ? 60 : 6;
            h = ($urandom_range(rate - 1) == 0) ? (($urandom_range(1) == 0) ? 2'b00 : 2'b11)
                                                : (($urandom_range(1) == 0) ? 2'b01 : 2'b10);
            cycle(($urandom_range(799) != 0), ($urandom_range(9) != 0),
                  ($urandom_range(6) != 0), h);
        end
        cycle(1, 1, 0, 2'b00);
        @(posedge clk);
        @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending entries required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
